// File: rtl/cdc_launch_pkg.sv
// Shared types and constants for the source half of the toggle-handshake bus crossing.
package cdc_launch_pkg;

   typedef enum logic [1:0] {
      RESYNC   = 2'd0,
      IDLE     = 2'd1,
      WAIT_ACK = 2'd2
   } launch_state_t;

   // Fewer than two stages gives no metastability settling time.
   localparam int MIN_SYNC_DEPTH = 2;

endpackage

// File: rtl/cdc_ack_sync.sv
// Single-bit multi-flop synchronizer for the returned ack toggle.
module cdc_ack_sync #(
   parameter int SYNC_DEPTH = 2
) (
   input  logic i_clk,
   input  logic i_arst,
   input  logic i_d,
   output logic o_q
);

   (* async_reg = "true", dont_touch = "true", keep = "true", dont_replicate = "true" *)
   logic [SYNC_DEPTH-1:0] r_sync;

   // Shift the asynchronous input through the chain; all stages clear on reset.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) r_sync <= '0;
      else        r_sync <= {r_sync[SYNC_DEPTH-2:0], i_d};
   end

   assign o_q = r_sync[SYNC_DEPTH-1];

endmodule

// File: rtl/cdc_bus_launch.sv
// Source-domain launcher for a multi-bit toggle req/ack crossing.
// dout is frozen while a request is outstanding so the destination can
// capture it without per-bit synchronization.
// Optional ack-wait watchdog: define CDC_LAUNCH_TIMEOUT_EN.
module cdc_bus_launch #(
   parameter int WIDTH          = 32,
   parameter int SYNC_DEPTH     = 2,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 i_clk,
   input  logic                 i_arst,
   input  logic [WIDTH-1:0]     i_din,
   input  logic                 i_din_valid,
   output logic                 o_din_ready,
   output logic [WIDTH-1:0]     o_dout,
   output logic                 o_req_toggle,
   input  logic                 i_ack_toggle,
   output logic                 o_busy,
   output logic [CNT_WIDTH-1:0] o_launch_count,
   output logic                 o_timeout_err
);
   import cdc_launch_pkg::*;

   // Settle counter width: counts the cycles needed to flush reset zeros out of the ack chain.
   localparam int SW = $clog2(SYNC_DEPTH + 1);

   if (SYNC_DEPTH < MIN_SYNC_DEPTH) begin : g_depth_chk
      $error("cdc_bus_launch: SYNC_DEPTH must be >= %0d", MIN_SYNC_DEPTH);
   end
   if (TIMEOUT_CYCLES < 1) begin : g_to_chk
      $error("cdc_bus_launch: TIMEOUT_CYCLES must be >= 1");
   end

   launch_state_t          r_state, w_state_nxt;
   logic                   w_ack_s;
   logic                   w_launch;
   logic                   w_settled;
   logic [SW-1:0]          r_settle;
   logic [WIDTH-1:0]       r_dout;
   logic                   r_req;
   logic [CNT_WIDTH-1:0]   r_count;

   cdc_ack_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_ack_sync (
      .i_clk (i_clk),
      .i_arst(i_arst),
      .i_d   (i_ack_toggle),
      .o_q   (w_ack_s)
   );

   // The chain comes out of reset holding zeros, not the real ack level, so
   // RESYNC only trusts ack_s once SYNC_DEPTH fresh samples have shifted through.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst)                         r_settle <= '0;
      else if (r_settle != SW'(SYNC_DEPTH)) r_settle <= r_settle + SW'(1);
   end
   assign w_settled = (r_settle == SW'(SYNC_DEPTH));

   // State register.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) r_state <= RESYNC;
      else        r_state <= w_state_nxt;
   end

   // Next state and state-decoded handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      o_din_ready = 1'b0;
      o_busy      = 1'b0;
      unique case (r_state)
         RESYNC:   if (w_settled && (w_ack_s == r_req)) w_state_nxt = IDLE;
         IDLE: begin
            o_din_ready = 1'b1;
            if (i_din_valid) w_state_nxt = WAIT_ACK;
         end
         WAIT_ACK: begin
            o_busy = 1'b1;
            if (w_ack_s == r_req) w_state_nxt = IDLE;
         end
         default:  w_state_nxt = RESYNC;
      endcase
   end

   assign w_launch = (r_state == IDLE) && i_din_valid;

   // Launch datapath: word, toggle and statistics update together on acceptance.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_dout  <= '0;
         r_req   <= 1'b0;
         r_count <= '0;
      end else if (w_launch) begin
         r_dout  <= i_din;
         r_req   <= ~r_req;
         r_count <= r_count + CNT_WIDTH'(1);
      end
   end

   assign o_dout         = r_dout;
   assign o_req_toggle   = r_req;
   assign o_launch_count = r_count;

`ifdef CDC_LAUNCH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to_cnt;
   logic          r_to_err;

   // Count WAIT_ACK cycles for the current request; the flag is sticky and the FSM never aborts.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_to_cnt <= '0;
         r_to_err <= 1'b0;
      end else if (w_launch) begin
         r_to_cnt <= '0;
      end else if ((r_state == WAIT_ACK) && (r_to_cnt != TW'(TIMEOUT_CYCLES))) begin
         r_to_cnt <= r_to_cnt + TW'(1);
         if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) r_to_err <= 1'b1;
      end
   end
   assign o_timeout_err = r_to_err;
`else
   assign o_timeout_err = 1'b0;
`endif

endmodule
